lcb_rx_framer: RTL and testbench

Per-channel response framer between one LCB UART receiver and its 32-byte response buffer RAM. Hunts for the sync byte, writes each payload byte to sequential RAM addresses, times out stalled frames and verifies the trailing 8-bit checksum. Emits a one-cycle done strobe that starts the read-address sequencer and packers, or an error strobe with a code.

---
 rtl/lcb_rx_framer_pkg.sv | 24 ++
 rtl/lcb_rx_framer_if.sv | 44 ++++
 rtl/lcb_rx_framer_gap_timer.sv | 34 +++
 rtl/lcb_rx_framer.sv | 119 +++++++++++
 tb/tb_lcb_rx_framer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcb_rx_framer_pkg.sv
// Shared types and constants for the LCB receive framer.
// Build option: LCB_RX_ERRCNT_EN enables the error counter.
package lcb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;

  localparam logic [7:0] SYNC_DEF = 8'hAA;

  function automatic logic [7:0] csum_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/lcb_rx_framer_if.sv
// Byte-in / RAM-write-out bundle of the LCB receive framer.
// Build option: LCB_RX_ERRCNT_EN adds iErrClr/oErrCnt.
interface lcb_rx_framer_if #(
  parameter int ADDR_W = 5
);

  logic              iValid;
  logic [7:0]        iData;
  logic [7:0]        oData;
  logic [ADDR_W-1:0] oWrAdr;
  logic              oWE;
  logic              oDone;
  logic              oErr;
  logic [1:0]        oErrCode;
`ifdef LCB_RX_ERRCNT_EN
  logic              iErrClr;
  logic [7:0]        oErrCnt;

  modport master (
    output iValid, iData, iErrClr,
    input  oData, oWrAdr, oWE,
    input  oDone, oErr, oErrCode, oErrCnt
  );

  modport slave (
    input  iValid, iData, iErrClr,
    output oData, oWrAdr, oWE,
    output oDone, oErr, oErrCode, oErrCnt
  );
`else
  modport master (
    output iValid, iData,
    input  oData, oWrAdr, oWE,
    input  oDone, oErr, oErrCode
  );

  modport slave (
    input  iValid, iData,
    output oData, oWrAdr, oWE,
    output oDone, oErr, oErrCode
  );
`endif

endinterface

// File: rtl/lcb_rx_framer_gap_timer.sv
// Inter-byte gap counter with clear, load and expiry flag.
// Shared by the RX and TX framers.
module lcb_gap_timer #(
  parameter int GAP_TIMEOUT = 700,
  parameter int CW = $clog2(GAP_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expired
);

  logic [CW-1:0] cnt;

  // Flags the cycle in which the count would reach the limit.
  assign expired = en && (cnt == CW'(GAP_TIMEOUT - 1));

  // Count idle cycles; clear dominates load, load dominates count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcb_rx_framer.sv
// LCB response framer: sync hunt, RAM write, gap timeout, checksum.
// Build option: LCB_RX_ERRCNT_EN adds a saturating error counter.
module lcb_rx_framer
  import lcb_rx_pkg::*;
#(
  parameter int         FRAME_LEN   = 24,
  parameter int         ADDR_W      = 5,
  parameter logic [7:0] SYNC        = SYNC_DEF,
  parameter int         GAP_TIMEOUT = 700
) (
  input  logic           clk,
  input  logic           rst,
  lcb_rx_framer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam int CW = $clog2(GAP_TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        sum;
  logic [7:0]        csum;
  logic              gap_clr;
  logic              expired;

  // Gap count runs only while a frame is open and the line is quiet.
  assign gap_clr = (state != RECV) || bus.iValid;

  lcb_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clr      (gap_clr),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (1'b1),
    .expired  (expired)
  );

  // Frame FSM with registered RAM-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      sum          <= '0;
      csum         <= '0;
      bus.oData    <= '0;
      bus.oWrAdr   <= '0;
      bus.oWE      <= 1'b0;
      bus.oDone    <= 1'b0;
      bus.oErr     <= 1'b0;
      bus.oErrCode <= ERR_NONE;
    end else begin
      bus.oWE   <= 1'b0;
      bus.oDone <= 1'b0;
      bus.oErr  <= 1'b0;
      unique case (state)
        RECV: begin
          if (bus.iValid) begin
            bus.oWE    <= 1'b1;
            bus.oWrAdr <= idx;
            bus.oData  <= bus.iData;
            if (idx == LAST) begin
              csum  <= bus.iData;
              idx   <= '0;
              state <= CHECK;
            end else begin
              sum <= csum_add(sum, bus.iData);
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            bus.oErr     <= 1'b1;
            bus.oErrCode <= ERR_TIMEOUT;
            idx          <= '0;
            state        <= IDLE;
          end
        end
        default: begin
          if (state == CHECK) begin
            if (sum == csum) begin
              bus.oDone <= 1'b1;
            end else begin
              bus.oErr     <= 1'b1;
              bus.oErrCode <= ERR_CSUM;
            end
            state <= IDLE;
          end
          if (bus.iValid && bus.iData == SYNC) begin
            bus.oWE    <= 1'b1;
            bus.oWrAdr <= '0;
            bus.oData  <= bus.iData;
            sum        <= SYNC;
            idx        <= ADDR_W'(1);
            state      <= RECV;
          end
        end
      endcase
    end
  end

`ifdef LCB_RX_ERRCNT_EN
  logic [7:0] err_cnt;

  assign bus.oErrCnt = err_cnt;

  // Saturating count of error pulses; clear wins over a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (bus.iErrClr) begin
      err_cnt <= '0;
    end else if (bus.oErr && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcb_rx_framer.sv
// Self-checking bench for lcb_rx_framer.
// Build option: LCB_RX_ERRCNT_EN also exercises the error counter.
module tb_lcb_rx_framer;

  localparam int FL = 24;
  localparam int AW = 5;
  localparam int GT = 700;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  lcb_rx_framer_if #(.ADDR_W(AW)) bus ();

  lcb_rx_framer #(
    .FRAME_LEN   (FL),
    .ADDR_W      (AW),
    .SYNC        (8'hAA),
    .GAP_TIMEOUT (GT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  longint exp_q[$];
  longint act_q[$];

  int overlap = 0;
  int held_bad = 0;
  logic [1:0] last_code = 2'b00;
  logic [AW-1:0] last_adr = '0;

  bit in_frame = 0;
  logic [7:0] fbuf[$];
  int last_e = 0;
  logic [7:0] frm[$];

  // kind: 0 write, 1 done, 2 error
  function automatic longint ev(int e, int k, int a, int d);
    return (longint'(e) << 16) | longint'(k << 13)
         | longint'(a << 8) | longint'(d);
  endfunction

  task automatic chk(string tag, longint got, longint want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference model: frame assembly from timestamped bytes.
  function automatic void model_byte(int e, logic [7:0] b);
    int s;
    if (in_frame && (e - last_e) > GT) begin
      exp_q.push_back(ev(last_e + GT, 2, 0, 1));
      in_frame = 0;
    end
    if (!in_frame) begin
      if (b == 8'hAA) begin
        in_frame = 1;
        fbuf = {};
        fbuf.push_back(b);
        exp_q.push_back(ev(e, 0, 0, int'(b)));
        last_e = e;
      end
    end else begin
      exp_q.push_back(ev(e, 0, fbuf.size(), int'(b)));
      fbuf.push_back(b);
      last_e = e;
      if (fbuf.size() == FL) begin
        s = 0;
        for (int i = 0; i < FL - 1; i++) s += int'(fbuf[i]);
        if ((s % 256) == int'(fbuf[FL-1]))
          exp_q.push_back(ev(e + 1, 1, 0, 0));
        else
          exp_q.push_back(ev(e + 1, 2, 0, 2));
        in_frame = 0;
      end
    end
  endfunction

  function automatic void model_flush(int now);
    if (in_frame && (now - last_e) >= GT) begin
      exp_q.push_back(ev(last_e + GT, 2, 0, 1));
      in_frame = 0;
    end
  endfunction

  // Event monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.oDone && bus.oErr) overlap++;
      if (bus.oDone) act_q.push_back(ev(edge_n, 1, 0, 0));
      if (bus.oErr) begin
        act_q.push_back(ev(edge_n, 2, 0, int'(bus.oErrCode)));
        last_code = bus.oErrCode;
      end else if (bus.oErrCode !== last_code) begin
        held_bad++;
      end
      if (bus.oWE) begin
        act_q.push_back(ev(edge_n, 0, int'(bus.oWrAdr), int'(bus.oData)));
        last_adr = bus.oWrAdr;
      end else if (bus.oWrAdr !== last_adr) begin
        held_bad++;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      bus.iValid = 1'b0;
      @(posedge clk);
      edge_n++;
      #1;
    end
  endtask

  task automatic send(logic [7:0] b, int gap);
    idle(gap - 1);
    bus.iValid = 1'b1;
    bus.iData  = b;
    @(posedge clk);
    edge_n++;
    model_byte(edge_n, b);
    #1;
    bus.iValid = 1'b0;
  endtask

  task automatic build_fixed(logic [7:0] last);
    frm = {};
    frm.push_back(8'hAA);
    for (int i = 1; i <= 22; i++) frm.push_back(8'(i));
    frm.push_back(last);
  endtask

  task automatic send_frm(int gap);
    foreach (frm[i]) send(frm[i], gap);
  endtask

  task automatic cmp_events(string tag);
    idle(2);
    model_flush(edge_n - 1);
    chk({tag, "/count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      chk(tag, act_q[i], exp_q[i]);
    act_q = {};
    exp_q = {};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int g;
    int s;

    bus.iValid = 1'b0;
    bus.iData  = 8'h00;
`ifdef LCB_RX_ERRCNT_EN
    bus.iErrClr = 1'b0;
`endif

    // reset values
    #12;
    chk("rst/oData", bus.oData, 0);
    chk("rst/oWrAdr", bus.oWrAdr, 0);
    chk("rst/oWE", bus.oWE, 0);
    chk("rst/oDone", bus.oDone, 0);
    chk("rst/oErr", bus.oErr, 0);
    chk("rst/oErrCode", bus.oErrCode, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);

    // good frame, checksum A7
    build_fixed(8'hA7);
    send_frm(10);
    idle(3);
    cmp_events("good");

    // bad checksum
    build_fixed(8'hA8);
    send_frm(10);
    idle(3);
    cmp_events("badsum");
    chk("badsum/code", bus.oErrCode, 2);

    // timeout then recovery
    send(8'hAA, 5);
    send(8'h01, 5);
    send(8'h02, 5);
    idle(GT + 20);
    cmp_events("timeout");
    chk("timeout/code", bus.oErrCode, 1);
    build_fixed(8'hA7);
    send_frm(4);
    idle(3);
    cmp_events("recover");

    // sync hunt
    send(8'h55, 3);
    send(8'h00, 3);
    send(8'hFF, 3);
    build_fixed(8'hA7);
    send_frm(3);
    idle(3);
    cmp_events("hunt");

    // gap of exactly the limit is accepted
    build_fixed(8'hA7);
    foreach (frm[i]) send(frm[i], (i == 5) ? GT : 3);
    idle(3);
    cmp_events("gap_eq");

    // gap of limit+1 times out and the late byte is discarded
    send(8'hAA, 3);
    send(8'h01, 3);
    send(8'h02, GT + 1);
    idle(3);
    cmp_events("gap_over");

    // sync arriving in the checksum-compare cycle
    build_fixed(8'hA7);
    send_frm(2);
    send_frm(1);
    idle(3);
    cmp_events("sync_check");

    // randomized frames with noise and occasional long gaps
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h55;
        send(b, int'($urandom_range(1, 6)));
      end
      frm = {};
      frm.push_back(8'hAA);
      s = 8'hAA;
      for (int i = 1; i < FL - 1; i++) begin
        b = 8'($urandom);
        frm.push_back(b);
        s += int'(b);
      end
      b = 8'(s);
      if ($urandom_range(0, 2) == 0) b = b ^ 8'(1 << $urandom_range(0, 7));
      frm.push_back(b);
      foreach (frm[i]) begin
        if ($urandom_range(0, 40) == 0) g = int'($urandom_range(GT - 5, GT + 5));
        else g = int'($urandom_range(1, 12));
        send(frm[i], g);
      end
      idle(int'($urandom_range(1, 4)));
    end
    idle(GT + 10);
    cmp_events("random");

    // reset mid-frame
    build_fixed(8'hA7);
    for (int i = 0; i < 10; i++) send(frm[i], 3);
    cmp_events("pre_reset");
    bus.iValid = 1'b1;
    bus.iData  = 8'h0A;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst/oData", bus.oData, 0);
    chk("midrst/oWrAdr", bus.oWrAdr, 0);
    chk("midrst/oWE", bus.oWE, 0);
    chk("midrst/oDone", bus.oDone, 0);
    chk("midrst/oErr", bus.oErr, 0);
    chk("midrst/oErrCode", bus.oErrCode, 0);
    @(posedge clk);
    edge_n++;
    #1;
    bus.iValid = 1'b0;
    in_frame = 0;
    last_code = 2'b00;
    last_adr = '0;
    rst = 1'b1;
    idle(GT + 10);
    chk("midrst/nopulse", act_q.size(), 0);
    send_frm(3);
    idle(3);
    cmp_events("post_reset");

`ifdef LCB_RX_ERRCNT_EN
    chk("errcnt/rst", bus.oErrCnt, 0);
    build_fixed(8'hA8);
    send_frm(1);
    idle(3);
    chk("errcnt/one", bus.oErrCnt, 1);
    for (int r = 0; r < 300; r++) send_frm(1);
    idle(3);
    chk("errcnt/sat", bus.oErrCnt, 8'hFF);
    cmp_events("errcnt_frames");
    bus.iErrClr = 1'b1;
    idle(1);
    bus.iErrClr = 1'b0;
    chk("errcnt/clr", bus.oErrCnt, 0);
    send_frm(1);
    idle(1);
    chk("errcnt/err_now", bus.oErr, 1);
    bus.iErrClr = 1'b1;
    idle(1);
    bus.iErrClr = 1'b0;
    chk("errcnt/clr_coinc", bus.oErrCnt, 0);
    idle(2);
    chk("errcnt/stay0", bus.oErrCnt, 0);
    cmp_events("errcnt_tail");
`endif

    chk("overlap", overlap, 0);
    chk("held", held_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
